axis_dwidth_down: RTL

Registered AXI4-Stream width down-converter. It accepts 512-bit beats from the traffic generator core and serialises each one into `512/DWIDTH` narrower beats, most-significant slice first. Ratio 1 (`DWIDTH=512`) degenerates to a one-deep register slice. It sits between the 512-bit generator datapath and narrower MAC/FIFO ports, and replaces top-slice truncation with lossless slicing plus `tlast` and `tkeep` handling.

---
 rtl/dwidth_pkg.sv | 16 +
 rtl/dwidth_slice_find.sv | 22 ++
 rtl/axis_dwidth_down.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dwidth_pkg.sv
// Shared constants, state type and ratio helper for the AXI4-Stream width down-converter.
package dwidth_pkg;

    localparam int AXIS_MAX_W  = 512;
    localparam int AXIS_MAX_KW = 64;

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } dwd_state_t;

    function automatic int ratio(input int dw);
        return AXIS_MAX_W / dw;
    endfunction

endpackage

// File: rtl/dwidth_slice_find.sv
// Priority encoder: index of the highest-numbered (least-significant) keep slice with any byte set.
// Returns 0 when every keep bit is clear.
module dwidth_slice_find
    import dwidth_pkg::*;
#(
    parameter  int DWIDTH = 128,
    localparam int R      = ratio(DWIDTH),
    localparam int IW     = (R > 1) ? $clog2(R) : 1,
    localparam int KW     = DWIDTH / 8
) (
    input  logic [AXIS_MAX_KW-1:0] i_keep,
    output logic [IW-1:0]          o_idx
);

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < R; k++) begin
            if (|i_keep[AXIS_MAX_KW-1-k*KW -: KW]) o_idx = IW'(k);
        end
    end

endmodule

// File: rtl/axis_dwidth_down.sv
// 512-bit to DWIDTH AXI4-Stream down-converter, most-significant slice first.
// Define AXIS_DWIDTH_DOWN_SKIP_NULL_EN to drop trailing all-zero keep slices of last beats.
module axis_dwidth_down
    import dwidth_pkg::*;
#(
    parameter  int DWIDTH = 128,
    localparam int R      = ratio(DWIDTH),
    localparam int IW     = (R > 1) ? $clog2(R) : 1,
    localparam int KW     = DWIDTH / 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [AXIS_MAX_W-1:0]  s_data,
    input  logic [AXIS_MAX_KW-1:0] s_keep,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DWIDTH-1:0]      m_data,
    output logic [KW-1:0]          m_keep,
    output logic                   m_last
);

    localparam logic [IW-1:0] FIN_MAX = IW'(R - 1);

    dwd_state_t             r_state;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          r_fin;
    logic [AXIS_MAX_W-1:0]  r_data;
    logic [AXIS_MAX_KW-1:0] r_keep;
    logic                   r_last;

    dwd_state_t             w_state_nx;
    logic [IW-1:0]          w_idx_nx;
    logic [IW-1:0]          w_fin_new;
    logic                   w_load;
    logic                   w_at_fin;
    logic                   w_s_hs;

`ifdef AXIS_DWIDTH_DOWN_SKIP_NULL_EN
    logic [IW-1:0] w_fin_hi;

    dwidth_slice_find #(.DWIDTH(DWIDTH)) u_find (
        .i_keep (s_keep),
        .o_idx  (w_fin_hi)
    );

    assign w_fin_new = s_last ? w_fin_hi : FIN_MAX;
`else
    assign w_fin_new = FIN_MAX;
`endif

    assign w_at_fin = (r_idx == r_fin);
    assign s_ready  = aresetn && ((r_state == EMPTY) || (w_at_fin && m_ready));
    assign w_s_hs   = s_valid && s_ready;
    assign m_valid  = (r_state == BUSY);
    assign m_last   = r_last && w_at_fin;

    generate
        if (R == 1) begin : g_pass
            assign m_data = r_data;
            assign m_keep = r_keep;
        end else begin : g_slice
            logic [R-1:0][DWIDTH-1:0] w_dsl;
            logic [R-1:0][KW-1:0]     w_ksl;
            for (genvar k = 0; k < R; k++) begin : g_k
                assign w_dsl[k] = r_data[AXIS_MAX_W-1-k*DWIDTH -: DWIDTH];
                assign w_ksl[k] = r_keep[AXIS_MAX_KW-1-k*KW -: KW];
            end
            assign m_data = w_dsl[r_idx];
            assign m_keep = w_ksl[r_idx];
        end
    endgenerate

    // Completing the final slice and accepting a new beat in one cycle keeps the output gap-free.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_load     = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_s_hs) begin
                    w_state_nx = BUSY;
                    w_load     = 1'b1;
                    w_idx_nx   = '0;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    if (!w_at_fin) begin
                        w_idx_nx = r_idx + 1'b1;
                    end else if (w_s_hs) begin
                        w_load   = 1'b1;
                        w_idx_nx = '0;
                    end else begin
                        w_state_nx = EMPTY;
                    end
                end
            end
            default: w_state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= EMPTY;
            r_idx   <= '0;
            r_fin   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            if (w_load) begin
                r_data <= s_data;
                r_keep <= s_keep;
                r_last <= s_last;
                r_fin  <= w_fin_new;
            end
        end
    end

endmodule
